// File: rtl/md_pkg.sv
// Shared types and constants for the market-data feed arbiter.
package md_pkg;

  localparam int CH_IDX_W = 3;

  localparam logic [7:0] ITCH_ADD    = 8'h41;
  localparam logic [7:0] ITCH_EXEC   = 8'h45;
  localparam logic [7:0] ITCH_CANCEL = 8'h58;

  typedef enum logic {
    IDLE,
    OWN
  } arb_state_t;

endpackage

// File: rtl/md_rr_pick.sv
// Combinational round-robin picker: first set request at or after 'start', wrapping.
module md_rr_pick
  import md_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]   req,
  input  logic [CH_IDX_W-1:0] start,
  output logic [NUM_CH-1:0]   gnt,
  output logic [CH_IDX_W-1:0] idx,
  output logic                any
);

  localparam logic [CH_IDX_W:0] NUM_W = (CH_IDX_W+1)'(NUM_CH);

  logic [NUM_CH-1:0]   rot;
  logic [CH_IDX_W-1:0] off;
  logic [CH_IDX_W:0]   sum;
  logic                found;

  // Rotate so 'start' lands at bit 0, then a fixed-priority scan finds the offset.
  always_comb begin
    rot   = NUM_CH'({req, req} >> start);
    any   = |rot;
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = CH_IDX_W'(k);
      end
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= NUM_W) sum = sum - NUM_W;
    idx = sum[CH_IDX_W-1:0];
    gnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      gnt[i] = any && (idx == CH_IDX_W'(i));
    end
  end

endmodule

// File: rtl/md_feed_arbiter.sv
// Sticky round-robin arbiter feeding one market-data processor ingress port from NUM_CH
// feed channels, with a registered output stage and arbitration counters.
module md_feed_arbiter
  import md_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int TYPE_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  input  logic [NUM_CH*TYPE_WIDTH-1:0] ch_type,
  output logic [NUM_CH-1:0]            ch_ready,
  input  logic [NUM_CH-1:0]            ch_enable,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [TYPE_WIDTH-1:0]        out_type,
  input  logic                         out_ready,
  output logic [CH_IDX_W-1:0]          out_channel,
  output logic [31:0]                  grant_total,
  output logic [31:0]                  wait_cycles
);

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  arb_state_t          state, state_nxt;
  logic [CH_IDX_W-1:0] owner, owner_nxt, last_owner, last_nxt;
  logic [7:0]          burst_cnt, burst_nxt;

  logic [NUM_CH-1:0]     eligible, owner_oh, pick_gnt, sel_gnt;
  logic [CH_IDX_W-1:0]   start, pick_idx, sel_idx;
  logic                  load, owner_elig, keep, pick_any, sel_any, xfer, waiting;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [TYPE_WIDTH-1:0] sel_type;

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [TYPE_WIDTH-1:0] type_p1;
  logic [CH_IDX_W-1:0]   chan_p1;

  function automatic logic [CH_IDX_W-1:0] next_idx(input logic [CH_IDX_W-1:0] i);
    return (i == CH_IDX_W'(NUM_CH-1)) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      owner_oh[i] = (owner == CH_IDX_W'(i));
    end
  end

  assign eligible   = ch_valid & ch_enable;
  assign load       = !vld_p1 | out_ready;
  assign owner_elig = |(eligible & owner_oh);
  // Owner keeps the grant under its burst limit, or indefinitely when nobody else wants it.
  assign keep       = (state == OWN) && owner_elig &&
                      ((burst_cnt < BURST_MAX) || ((eligible & ~owner_oh) == '0));
  assign start      = (state == IDLE) ? next_idx(last_owner) : next_idx(owner);

  md_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req   (eligible),
    .start (start),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign sel_gnt  = keep ? owner_oh : pick_gnt;
  assign sel_idx  = keep ? owner : pick_idx;
  assign sel_any  = keep | pick_any;
  assign ch_ready = {NUM_CH{load}} & sel_gnt;
  assign xfer     = |(ch_valid & ch_ready);
  assign waiting  = |(eligible & ~ch_ready);

  always_comb begin
    sel_data = '0;
    sel_type = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_gnt[i]) begin
        sel_data = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_type = ch_type[i*TYPE_WIDTH +: TYPE_WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    burst_nxt = burst_cnt;
    last_nxt  = last_owner;
    if (load) begin
      if (sel_any) begin
        state_nxt = OWN;
        owner_nxt = sel_idx;
        burst_nxt = keep ? ((burst_cnt < BURST_MAX) ? burst_cnt + 8'd1 : burst_cnt) : 8'd1;
      end else if (state == OWN) begin
        state_nxt = IDLE;
        last_nxt  = owner;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      burst_cnt  <= '0;
      last_owner <= CH_IDX_W'(NUM_CH-1);
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      burst_cnt  <= burst_nxt;
      last_owner <= last_nxt;
    end
  end

  // Stage p1: output register toward the processor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      type_p1 <= '0;
      chan_p1 <= '0;
    end else if (load) begin
      vld_p1 <= xfer;
      if (xfer) begin
        data_p1 <= sel_data;
        type_p1 <= sel_type;
        chan_p1 <= sel_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_total <= '0;
      wait_cycles <= '0;
    end else begin
      if (xfer)    grant_total <= grant_total + 32'd1;
      if (waiting) wait_cycles <= wait_cycles + 32'd1;
    end
  end

  assign out_valid   = vld_p1;
  assign out_data    = data_p1;
  assign out_type    = type_p1;
  assign out_channel = chan_p1;

endmodule

// File: tb/tb_md_feed_arbiter.sv
// Directed bench for md_feed_arbiter: reset, burst rotation, enable drop, stall, mid-run reset.
module tb_md_feed_arbiter;
  import md_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DW     = 64;
  localparam int TW     = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_CH-1:0]      ch_valid = '0;
  logic [NUM_CH*DW-1:0]   ch_data = '0;
  logic [NUM_CH*TW-1:0]   ch_type = '0;
  logic [NUM_CH-1:0]      ch_ready;
  logic [NUM_CH-1:0]      ch_enable = '1;
  logic                   out_valid;
  logic [DW-1:0]          out_data;
  logic [TW-1:0]          out_type;
  logic                   out_ready = 1'b1;
  logic [CH_IDX_W-1:0]    out_channel;
  logic [31:0]            grant_total;
  logic [31:0]            wait_cycles;

  int n_vec = 0;
  int n_err = 0;

  md_feed_arbiter #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .TYPE_WIDTH(TW), .MAX_BURST(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_data(ch_data), .ch_type(ch_type),
    .ch_ready(ch_ready), .ch_enable(ch_enable), .out_valid(out_valid), .out_data(out_data),
    .out_type(out_type), .out_ready(out_ready), .out_channel(out_channel),
    .grant_total(grant_total), .wait_cycles(wait_cycles)
  );

  always #2 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [DW-1:0] d, input logic [TW-1:0] t);
    ch_data[i*DW +: DW] = d;
    ch_type[i*TW +: TW] = t;
  endtask

  task automatic do_reset();
    ch_valid  = '0;
    ch_enable = '1;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ch_valid = '0;
    rst_n    = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    n_vec++; if (out_type !== '0) begin n_err++; $display("FAIL rst_out_type: got %h want 0", out_type); end
    n_vec++; if (out_channel !== '0) begin n_err++; $display("FAIL rst_out_channel: got %0d want 0", out_channel); end
    n_vec++; if (ch_ready !== '0) begin n_err++; $display("FAIL rst_ch_ready: got %b want 0000", ch_ready); end
    n_vec++; if (grant_total !== 32'd0) begin n_err++; $display("FAIL rst_grant_total: got %0d want 0", grant_total); end
    n_vec++; if (wait_cycles !== 32'd0) begin n_err++; $display("FAIL rst_wait_cycles: got %0d want 0", wait_cycles); end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    set_ch(0, 64'h41415054_32000000, ITCH_ADD);
    ch_valid = 4'b0001;
    #1;
    n_vec++; if (ch_ready !== 4'b0001) begin n_err++; $display("FAIL t1_ch_ready: got %b want 0001", ch_ready); end
    tick();
    ch_valid = '0;
    #1;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL t1_out_valid: got %0b want 1", out_valid); end
    n_vec++; if (out_channel !== 3'd0) begin n_err++; $display("FAIL t1_out_channel: got %0d want 0", out_channel); end
    n_vec++; if (out_type !== 8'h41) begin n_err++; $display("FAIL t1_out_type: got %h want 41", out_type); end
    n_vec++; if (out_data !== 64'h41415054_32000000) begin n_err++; $display("FAIL t1_out_data: got %h want 4141505432000000", out_data); end
    n_vec++; if (grant_total !== 32'd1) begin n_err++; $display("FAIL t1_grant_total: got %0d want 1", grant_total); end
    n_vec++; if (wait_cycles !== 32'd0) begin n_err++; $display("FAIL t1_wait_cycles: got %0d want 0", wait_cycles); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL t1_out_valid_drop: got %0b want 0", out_valid); end
  endtask

  task automatic test_burst_rotation();
    logic [2:0] exp_ch;
    logic [NUM_CH-1:0] exp_rdy;
    do_reset();
    ch_valid = 4'b0011;
    for (int k = 0; k < 24; k++) begin
      exp_ch  = ((k / 8) % 2 == 0) ? 3'd0 : 3'd1;
      exp_rdy = (exp_ch == 3'd0) ? 4'b0001 : 4'b0010;
      #1;
      n_vec++; if (ch_ready !== exp_rdy) begin n_err++; $display("FAIL t2_ch_ready[%0d]: got %b want %b", k, ch_ready, exp_rdy); end
      tick();
      n_vec++; if (out_valid !== 1'b1 || out_channel !== exp_ch) begin
        n_err++; $display("FAIL t2_out_channel[%0d]: got v=%0b ch=%0d want v=1 ch=%0d", k, out_valid, out_channel, exp_ch);
      end
    end
    n_vec++; if (wait_cycles !== 32'd24) begin n_err++; $display("FAIL t2_wait_cycles: got %0d want 24", wait_cycles); end
    n_vec++; if (grant_total !== 32'd24) begin n_err++; $display("FAIL t2_grant_total: got %0d want 24", grant_total); end
    ch_valid = '0;
  endtask

  task automatic test_single_stream();
    do_reset();
    ch_valid = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      #1;
      n_vec++; if (ch_ready !== 4'b0100) begin n_err++; $display("FAIL t3_ch_ready[%0d]: got %b want 0100", k, ch_ready); end
      tick();
      n_vec++; if (out_channel !== 3'd2) begin n_err++; $display("FAIL t3_out_channel[%0d]: got %0d want 2", k, out_channel); end
    end
    n_vec++; if (wait_cycles !== 32'd0) begin n_err++; $display("FAIL t3_wait_cycles: got %0d want 0", wait_cycles); end
    n_vec++; if (grant_total !== 32'd20) begin n_err++; $display("FAIL t3_grant_total: got %0d want 20", grant_total); end
    ch_valid = '0;
  endtask

  task automatic test_enable_drop();
    do_reset();
    set_ch(1, 64'h1111_0000_0000_0001, ITCH_EXEC);
    set_ch(2, 64'h2222_0000_0000_0002, ITCH_CANCEL);
    ch_valid = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if (out_channel !== 3'd1) begin n_err++; $display("FAIL t4_owner[%0d]: got %0d want 1", k, out_channel); end
    end
    ch_enable = 4'b1101;
    #1;
    n_vec++; if (ch_ready !== 4'b0100) begin n_err++; $display("FAIL t4_ch_ready: got %b want 0100", ch_ready); end
    n_vec++; if (out_valid !== 1'b1 || out_channel !== 3'd1) begin
      n_err++; $display("FAIL t4_held_word: got v=%0b ch=%0d want v=1 ch=1", out_valid, out_channel);
    end
    n_vec++; if (out_data !== 64'h1111_0000_0000_0001) begin n_err++; $display("FAIL t4_held_data: got %h want 1111000000000001", out_data); end
    tick();
    n_vec++; if (out_channel !== 3'd2 || out_type !== 8'h58) begin
      n_err++; $display("FAIL t4_rotated: got ch=%0d type=%h want ch=2 type=58", out_channel, out_type);
    end
    ch_valid  = '0;
    ch_enable = '1;
  endtask

  task automatic test_stall();
    logic [2:0] exp_ch;
    logic [NUM_CH-1:0] exp_rdy;
    do_reset();
    set_ch(0, 64'hAAAA_0000_0000_0000, ITCH_ADD);
    set_ch(3, 64'h3333_0000_0000_0003, ITCH_CANCEL);
    ch_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (ch_ready !== 4'b0001) begin n_err++; $display("FAIL t5_pre_ready[%0d]: got %b want 0001", k, ch_ready); end
      tick();
    end
    n_vec++; if (wait_cycles !== 32'd3) begin n_err++; $display("FAIL t5_wait_pre: got %0d want 3", wait_cycles); end
    out_ready = 1'b0;
    set_ch(0, 64'hBBBB_0000_0000_0000, ITCH_EXEC);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_vec++; if (ch_ready !== 4'b0000) begin n_err++; $display("FAIL t5_stall_ready[%0d]: got %b want 0000", k, ch_ready); end
      n_vec++; if (out_valid !== 1'b1 || out_channel !== 3'd0 || out_type !== 8'h41 || out_data !== 64'hAAAA_0000_0000_0000) begin
        n_err++; $display("FAIL t5_stall_hold[%0d]: got v=%0b ch=%0d type=%h data=%h want v=1 ch=0 type=41 data=aaaa000000000000",
                          k, out_valid, out_channel, out_type, out_data);
      end
      tick();
    end
    n_vec++; if (wait_cycles !== 32'd8) begin n_err++; $display("FAIL t5_wait_stall: got %0d want 8", wait_cycles); end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_ch  = (k < 5) ? 3'd0 : 3'd3;
      exp_rdy = (k < 5) ? 4'b0001 : 4'b1000;
      #1;
      n_vec++; if (ch_ready !== exp_rdy) begin n_err++; $display("FAIL t5_resume_ready[%0d]: got %b want %b", k, ch_ready, exp_rdy); end
      tick();
      n_vec++; if (out_channel !== exp_ch) begin n_err++; $display("FAIL t5_resume_ch[%0d]: got %0d want %0d", k, out_channel, exp_ch); end
    end
    n_vec++; if (grant_total !== 32'd9) begin n_err++; $display("FAIL t5_grant_total: got %0d want 9", grant_total); end
    ch_valid = '0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    ch_valid = 4'b0110;
    tick();
    tick();
    n_vec++; if (out_valid !== 1'b1 || grant_total !== 32'd2) begin
      n_err++; $display("FAIL t6_pre: got v=%0b grants=%0d want v=1 grants=2", out_valid, grant_total);
    end
    rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL t6_async_valid: got %0b want 0", out_valid); end
    n_vec++; if (grant_total !== 32'd0 || wait_cycles !== 32'd0) begin
      n_err++; $display("FAIL t6_async_cnt: got grants=%0d waits=%0d want 0/0", grant_total, wait_cycles);
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_vec++; if (ch_ready !== 4'b0010) begin n_err++; $display("FAIL t6_first_ready: got %b want 0010", ch_ready); end
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_channel !== 3'd1 || grant_total !== 32'd1) begin
      n_err++; $display("FAIL t6_first_grant: got v=%0b ch=%0d grants=%0d want v=1 ch=1 grants=1", out_valid, out_channel, grant_total);
    end
    ch_valid = '0;
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      set_ch(i, {32'hFEED0000 | 32'(i), 32'h0}, ITCH_ADD);
    end
    test_reset();
    test_single();
    test_burst_rotation();
    test_single_stream();
    test_enable_drop();
    test_stall();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
